regfile_sb: RTL and testbench

Parametrised register file with one write port, two asynchronous read ports, a per-register pending scoreboard, and a sequential sweep-clear engine. It sits in the decode/writeback stage of the pipelined core and replaces the fixed 32x32 register file. Decode marks destination registers pending at issue, and writeback clears them. Register 0 is hardwired to zero.

---
 rtl/regfile_sb.sv | 172 +++++++++++++++++
 tb/tb_regfile_sb.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb -- register file with a per-register pending scoreboard and a
// sequential sweep-clear engine.
//
// Purpose:
//   DEPTH x DATA_WIDTH register file (DEPTH = 2**ADDR_WIDTH), one write port,
//   two combinational read ports. Each entry carries a pending bit: decode sets
//   it at issue, writeback clears it. Entry 0 is constant zero, never pending,
//   and has no storage. ctrl_clear starts a sweep that zeroes entries 1..DEPTH-1,
//   one per clock; writes, issues and further clears are dropped while it runs.
//
// Ports:
//   clock             in   posedge clock
//   ctrl_reset_n      in   asynchronous active-low reset
//   ctrl_writeEnable  in   write strobe
//   ctrl_writeReg     in   write address (ADDR_WIDTH)
//   data_writeReg     in   write data (DATA_WIDTH)
//   ctrl_readRegA/B   in   read addresses (ADDR_WIDTH)
//   data_readRegA/B   out  read data (DATA_WIDTH)
//   ctrl_issueEnable  in   mark ctrl_issueReg pending
//   ctrl_issueReg     in   destination address to mark pending (ADDR_WIDTH)
//   pend_readRegA/B   out  pending flag of the addressed register
//   ctrl_clear        in   start a sweep clear
//   clear_busy        out  sweep clear in progress
//
// Configuration:
//   REGFILE_BYPASS_EN  when defined, an accepted same-cycle write is forwarded
//                      to a matching read port (data and pending flag).

module regfile_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  ctrl_reset_n,
    input  logic                  ctrl_writeEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_writeReg,
    input  logic [DATA_WIDTH-1:0] data_writeReg,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegA,
    input  logic [ADDR_WIDTH-1:0] ctrl_readRegB,
    output logic [DATA_WIDTH-1:0] data_readRegA,
    output logic [DATA_WIDTH-1:0] data_readRegB,
    input  logic                  ctrl_issueEnable,
    input  logic [ADDR_WIDTH-1:0] ctrl_issueReg,
    output logic                  pend_readRegA,
    output logic                  pend_readRegB,
    input  logic                  ctrl_clear,
    output logic                  clear_busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    logic idle;
    logic wr_ok;
    logic iss_ok;

    assign idle   = (state_q == S_IDLE);
    assign wr_ok  = ctrl_writeEnable && idle && (ctrl_writeReg != '0);
    assign iss_ok = ctrl_issueEnable && idle && (ctrl_issueReg != '0);

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = ADDR_WIDTH'(1);   // entry 0 has nothing to clear
                end
            end
            S_CLEAR: begin
                // Stop on the last entry so the counter never wraps to 0.
                if (cnt_q == LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign clear_busy = (state_q == S_CLEAR);

    // ---------------- storage ----------------
    logic [DATA_WIDTH-1:0] rd_mem [DEPTH];
    logic [DEPTH-1:0]      rd_pend;

    assign rd_mem[0]  = '0;
    assign rd_pend[0] = 1'b0;

    for (genvar e = 1; e < DEPTH; e++) begin : g_ent
        logic [DATA_WIDTH-1:0] data_q, data_d;
        logic                  pend_q, pend_d;

        always_comb begin
            data_d = data_q;
            pend_d = pend_q;
            if (clear_busy && (cnt_q == ADDR_WIDTH'(e))) begin
                data_d = '0;
                pend_d = 1'b0;
            end else begin
                if (wr_ok && (ctrl_writeReg == ADDR_WIDTH'(e))) begin
                    data_d = data_writeReg;
                    pend_d = 1'b0;
                end
                // Applied after the write so a same-address issue wins.
                if (iss_ok && (ctrl_issueReg == ADDR_WIDTH'(e))) begin
                    pend_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clock or negedge ctrl_reset_n) begin
            if (!ctrl_reset_n) begin
                data_q <= '0;
                pend_q <= 1'b0;
            end else begin
                data_q <= data_d;
                pend_q <= pend_d;
            end
        end

        assign rd_mem[e]  = data_q;
        assign rd_pend[e] = pend_q;
    end

    // ---------------- read ports ----------------
`ifdef REGFILE_BYPASS_EN
    logic byp_a, byp_b;

    // wr_ok already excludes address 0 and the sweep.
    assign byp_a = wr_ok && (ctrl_writeReg == ctrl_readRegA);
    assign byp_b = wr_ok && (ctrl_writeReg == ctrl_readRegB);

    assign data_readRegA = byp_a ? data_writeReg : rd_mem[ctrl_readRegA];
    assign data_readRegB = byp_b ? data_writeReg : rd_mem[ctrl_readRegB];
    assign pend_readRegA = byp_a ? (iss_ok && (ctrl_issueReg == ctrl_readRegA))
                                 : rd_pend[ctrl_readRegA];
    assign pend_readRegB = byp_b ? (iss_ok && (ctrl_issueReg == ctrl_readRegB))
                                 : rd_pend[ctrl_readRegB];
`else
    assign data_readRegA = rd_mem[ctrl_readRegA];
    assign data_readRegB = rd_mem[ctrl_readRegB];
    assign pend_readRegA = rd_pend[ctrl_readRegA];
    assign pend_readRegB = rd_pend[ctrl_readRegB];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (default 32 x 32). A behavioural model
// (plain arrays plus a sweep position) predicts every read each cycle.

module tb_regfile_sb;

    logic        clock;
    logic        rst_n;
    logic        we, ie, clr;
    logic [4:0]  wa, ia, ra, rb;
    logic [31:0] wd;
    logic [31:0] rda, rdb;
    logic        pda, pdb, busy;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock            (clock),
        .ctrl_reset_n     (rst_n),
        .ctrl_writeEnable (we),
        .ctrl_writeReg    (wa),
        .data_writeReg    (wd),
        .ctrl_readRegA    (ra),
        .ctrl_readRegB    (rb),
        .data_readRegA    (rda),
        .data_readRegB    (rdb),
        .ctrl_issueEnable (ie),
        .ctrl_issueReg    (ia),
        .pend_readRegA    (pda),
        .pend_readRegB    (pdb),
        .ctrl_clear       (clr),
        .clear_busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_busy;
    int          m_pos;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_pos  = 0;
    endtask

    // One posedge worth of behaviour, from the current inputs.
    task automatic model_tick();
        if (!rst_n) return;
        if (m_busy) begin
            m_mem[m_pos]  = '0;
            m_pend[m_pos] = 1'b0;
            if (m_pos == 31) m_busy = 1'b0;
            else             m_pos++;
        end else begin
            if (clr) begin
                m_busy = 1'b1;
                m_pos  = 1;
            end
            if (we && wa != 0) begin
                m_mem[wa]  = wd;
                m_pend[wa] = 1'b0;
            end
            if (ie && ia != 0) m_pend[ia] = 1'b1;
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n && !m_busy && we && wa != 0 && wa == a) return wd;
`endif
        return m_mem[a];
    endfunction

    function automatic logic exp_pd(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
        if (rst_n && !m_busy && we && wa != 0 && wa == a)
            return (ie && ia == a);
`endif
        return m_pend[a];
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("rdA",  rda, exp_rd(ra));
        chk("rdB",  rdb, exp_rd(rb));
        chk("pdA",  32'(pda), 32'(exp_pd(ra)));
        chk("pdB",  32'(pdb), 32'(exp_pd(rb)));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    // Called at posedge+1: check mid-cycle, advance one clock, return at posedge+1.
    task automatic step();
        #2;
        check_all();
        @(posedge clock);
        model_tick();
        #1;
    endtask

    task automatic idle_in();
        we = 1'b0; ie = 1'b0; clr = 1'b0;
    endtask

    int cnt, guard;

    initial begin
        rst_n = 1'b0;
        idle_in();
        wa = '0; ia = '0; wd = '0; ra = 5'd5; rb = 5'd7;
        model_reset();
        #2;
        chk("rst_rdA", rda, 32'h0);
        chk("rst_rdB", rdb, 32'h0);
        chk("rst_pd",  32'({pda, pdb}), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        // Write r5, read back A=5, B=0.
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
        step();
        idle_in(); ra = 5'd5; rb = 5'd0;
        #1;
        chk("w5_rdA", rda, 32'hDEADBEEF);
        chk("w5_rdB", rdb, 32'h0);
        chk("w5_pd",  32'({pda, pdb}), 32'h0);
        step();

        // Issue r7, write it two cycles later.
        ie = 1'b1; ia = 5'd7; ra = 5'd7;
        step();
        idle_in();
        #1 chk("iss7_c1", 32'(pda), 32'h1);
        step();
        #1 chk("iss7_c2", 32'(pda), 32'h1);
        we = 1'b1; wa = 5'd7; wd = 32'h1234;
        step();
        idle_in();
        #1;
        chk("wb7_pd", 32'(pda), 32'h0);
        chk("wb7_rd", rda, 32'h1234);
        step();

        // Simultaneous issue + write: issue wins.
        we = 1'b1; wa = 5'd7; wd = 32'h1234; ie = 1'b1; ia = 5'd7;
        step();
        idle_in();
        #1;
        chk("both7_pd", 32'(pda), 32'h1);
        chk("both7_rd", rda, 32'h1234);
        step();

        // Address 0 drops writes and issues.
        we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ie = 1'b1; ia = 5'd0; ra = 5'd0;
        step();
        idle_in();
        #1;
        chk("r0_rd", rda, 32'h0);
        chk("r0_pd", 32'(pda), 32'h0);
        step();

        // Same-cycle write and read of r3.
        we = 1'b1; wa = 5'd3; wd = 32'h11111111;
        step();
        we = 1'b1; wa = 5'd3; wd = 32'hA5A5A5A5; ra = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp3_same", rda, 32'hA5A5A5A5);
`else
        chk("byp3_same", rda, 32'h11111111);
`endif
        step();
        idle_in();
        #1 chk("byp3_next", rda, 32'hA5A5A5A5);
        step();

        // Fill and issue everything, then sweep.
        for (int i = 1; i < 32; i++) begin
            we = 1'b1; wa = 5'(i); wd = $urandom | 32'h1;
            ie = 1'b1; ia = 5'(i);
            ra = 5'(i); rb = 5'($urandom_range(0, 31));
            step();
        end
        idle_in();
        clr = 1'b1;
        step();
        clr = 1'b0;
        cnt = 0; guard = 0;
        while (busy === 1'b1 && guard < 100) begin
            if (cnt == 5) begin
                we = 1'b1; wa = 5'd9; wd = 32'h55; ie = 1'b1; ia = 5'd9;
            end else begin
                we = 1'b0; ie = 1'b0;
            end
            ra = 5'($urandom_range(0, 31)); rb = 5'($urandom_range(0, 31));
            cnt++; guard++;
            step();
        end
        idle_in();
        chk("sweep_len", 32'(cnt), 32'd31);
        for (int i = 0; i < 32; i++) begin
            ra = 5'(i); rb = 5'(31 - i);
            #1;
            chk("post_rdA", rda, 32'h0);
            chk("post_rdB", rdb, 32'h0);
            chk("post_pd",  32'({pda, pdb}), 32'h0);
            step();
        end

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            we  = 1'($urandom_range(0, 1));
            ie  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 63) == 0);
            wa  = 5'($urandom_range(0, 31));
            ia  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            rb  = 5'($urandom_range(0, 31));
            step();
        end
        idle_in();

        // Let any sweep finish, then reset in the middle of a new one.
        guard = 0;
        while (m_busy && guard < 100) begin
            guard++;
            step();
        end
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (9) step();
        ra = 5'd31; rb = 5'd30;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_rdA", rda, 32'h0);
        chk("arst_rdB", rdb, 32'h0);
        chk("arst_pd",  32'({pda, pdb}), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        step();
        rst_n = 1'b1;
        we = 1'b1; wa = 5'd31; wd = 32'hCAFEF00D;
        step();
        idle_in(); ra = 5'd31;
        #1;
        chk("arst_w31", rda, 32'hCAFEF00D);
        chk("arst_busy2", 32'(busy), 32'h0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
